// File: rtl/seq_alu.sv
// Sequential ALU: registered results, valid/ready on both sides, and an iterative shift-add multiplier.
// Optional macro SEQ_ALU_OVF_EN adds a registered signed-overflow output (ovf).
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [2:0]           op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 cb,
   output logic                 zero
`ifdef SEQ_ALU_OVF_EN
   ,
   output logic                 ovf
`endif
);

   localparam int RW = 2 * WIDTH;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_SHL = 3'b011;
   localparam logic [2:0] OP_SHR = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [RW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [RW-1:0]    r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [RW-1:0]    r_result;
   logic             r_cb;
   logic             r_zero;

   logic             w_accept;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_shl;
   logic [WIDTH-1:0] w_shr;
   logic [RW-1:0]    w_alu_res;
   logic             w_alu_cb;
   logic [RW-1:0]    w_mul_sum;
   logic             w_mul_last;

`ifdef SEQ_ALU_OVF_EN
   logic             r_ovf;
   logic             w_alu_ovf;
`endif

   function automatic logic [RW-1:0] zext(input logic [WIDTH-1:0] v);
      return {{WIDTH{1'b0}}, v};
   endfunction

   assign w_accept   = in_valid && (r_state == IDLE);
   assign w_add      = {1'b0, a} + {1'b0, b};
   assign w_sub      = {1'b0, a} - {1'b0, b};
   assign w_shl      = a << b;
   assign w_shr      = a >> b;
   assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_last = (r_cnt == CNT_LAST);

   // Single-cycle ops; the multiply path is handled by the iterative datapath below.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      w_alu_res = '0;
      w_alu_cb  = 1'b0;
`ifdef SEQ_ALU_OVF_EN
      w_alu_ovf = 1'b0;
`endif
      case (op)
         OP_ADD: begin
            w_alu_res = zext(w_add[WIDTH-1:0]);
            w_alu_cb  = w_add[WIDTH];
`ifdef SEQ_ALU_OVF_EN
            w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
`endif
         end
         OP_SUB: begin
            w_alu_res = zext(w_sub[WIDTH-1:0]);
            w_alu_cb  = w_sub[WIDTH];
`ifdef SEQ_ALU_OVF_EN
            w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
`endif
         end
         OP_SHL: w_alu_res = (b < SHIFT_LIM) ? zext(w_shl) : '0;
         OP_SHR: w_alu_res = (b < SHIFT_LIM) ? zext(w_shr) : '0;
         OP_AND: w_alu_res = zext(a & b);
         OP_OR:  w_alu_res = zext(a | b);
         OP_XOR: w_alu_res = zext(a ^ b);
         default: w_alu_res = '0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_nxt = (op == OP_MUL) ? MUL : DONE;
         MUL:  if (w_mul_last) w_state_nxt = DONE;
         DONE: if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_cb     <= 1'b0;
         r_zero   <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (op == OP_MUL) begin
                     r_mcand  <= zext(a);
                     r_mplier <= b;
                     r_acc    <= '0;
                     r_cnt    <= CNT_LOAD;
                  end else begin
                     r_result <= w_alu_res;
                     r_cb     <= w_alu_cb;
                     r_zero   <= (w_alu_res == '0);
`ifdef SEQ_ALU_OVF_EN
                     r_ovf    <= w_alu_ovf;
`endif
                  end
               end
            end
            MUL: begin
               r_acc    <= w_mul_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - CNT_LAST;
               // The final partial sum is the product; publish it on the last iteration.
               if (w_mul_last) begin
                  r_result <= w_mul_sum;
                  r_cb     <= 1'b0;
                  r_zero   <= (w_mul_sum == '0);
`ifdef SEQ_ALU_OVF_EN
                  r_ovf    <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign cb        = r_cb;
   assign zero      = r_zero;
`ifdef SEQ_ALU_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vectors, arithmetic reference model, backpressure and reset abort.
// Checks ovf as well when SEQ_ALU_OVF_EN is defined.
module tb_seq_alu;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2:0]     op;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;
   logic           cb;
   logic           zero;
`ifdef SEQ_ALU_OVF_EN
   logic           ovf;
`endif

   int checks   = 0;
   int failures = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cb        (cb),
      .zero      (zero)
`ifdef SEQ_ALU_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2*W-1:0] res;
      logic           cb;
      logic           z;
      logic           ovf;
   } mexp_t;

   typedef struct packed {
      logic [2:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] res;
      logic           cb;
      logic           z;
      logic           ovf;
      logic [7:0]     lat;
   } vec_t;

   // Hand-computed expectations; lat counts cycles from the accept edge to the first out_valid cycle.
   localparam vec_t VECS [0:14] = '{
      '{3'd0, 8'd200,  8'd100,  16'h002C, 1'b1, 1'b0, 1'b0, 8'd1},
      '{3'd0, 8'd100,  8'd100,  16'h00C8, 1'b0, 1'b0, 1'b1, 8'd1},
      '{3'd0, 8'd255,  8'd1,    16'h0000, 1'b1, 1'b1, 1'b0, 8'd1},
      '{3'd1, 8'd5,    8'd10,   16'h00FB, 1'b1, 1'b0, 1'b0, 8'd1},
      '{3'd1, 8'd7,    8'd7,    16'h0000, 1'b0, 1'b1, 1'b0, 8'd1},
      '{3'd1, 8'h80,   8'd1,    16'h007F, 1'b0, 1'b0, 1'b1, 8'd1},
      '{3'd2, 8'd255,  8'd255,  16'hFE01, 1'b0, 1'b0, 1'b0, 8'd9},
      '{3'd2, 8'd0,    8'd255,  16'h0000, 1'b0, 1'b1, 1'b0, 8'd9},
      '{3'd2, 8'd3,    8'd5,    16'h000F, 1'b0, 1'b0, 1'b0, 8'd9},
      '{3'd3, 8'h81,   8'd1,    16'h0002, 1'b0, 1'b0, 1'b0, 8'd1},
      '{3'd3, 8'h81,   8'd9,    16'h0000, 1'b0, 1'b1, 1'b0, 8'd1},
      '{3'd4, 8'h81,   8'd7,    16'h0001, 1'b0, 1'b0, 1'b0, 8'd1},
      '{3'd4, 8'h81,   8'd8,    16'h0000, 1'b0, 1'b1, 1'b0, 8'd1},
      '{3'd5, 8'hF0,   8'h3C,   16'h0030, 1'b0, 1'b0, 1'b0, 8'd1},
      '{3'd6, 8'hF0,   8'h3C,   16'h00FC, 1'b0, 1'b0, 1'b0, 8'd1}
   };

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic mexp_t model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      longint ua = longint'(av);
      longint ub = longint'(bv);
      longint m  = longint'(1) << W;
      longint h  = m / 2;
      longint sa = (ua >= h) ? ua - m : ua;
      longint sb = (ub >= h) ? ub - m : ub;
      longint r  = 0;
      longint s  = 0;
      mexp_t  e;
      e.cb  = 1'b0;
      e.ovf = 1'b0;
      case (o)
         3'd0: begin r = (ua + ub) % m; e.cb = (ua + ub) >= m; s = sa + sb; e.ovf = (s < -h) || (s >= h); end
         3'd1: begin r = (ua - ub + m) % m; e.cb = ua < ub; s = sa - sb; e.ovf = (s < -h) || (s >= h); end
         3'd2: r = ua * ub;
         3'd3: r = (ub >= W) ? 0 : (ua << ub) % m;
         3'd4: r = (ub >= W) ? 0 : ua >> ub;
         3'd5: r = ua & ub;
         3'd6: r = ua | ub;
         default: r = ua ^ ub;
      endcase
      e.res = r[2*W-1:0];
      e.z   = (r == 0);
      return e;
   endfunction

   mexp_t exp_cur;
   logic  exp_valid = 1'b0;

   // Whenever a result is presented it must match the model for the last accepted operation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         check("mon expected_pending", {31'd0, exp_valid}, 32'd1);
         check("mon result", {16'd0, result}, {16'd0, exp_cur.res});
         check("mon cb", {31'd0, cb}, {31'd0, exp_cur.cb});
         check("mon zero", {31'd0, zero}, {31'd0, exp_cur.z});
`ifdef SEQ_ALU_OVF_EN
         check("mon ovf", {31'd0, ovf}, {31'd0, exp_cur.ovf});
`endif
      end
   end

   task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("in_ready wait timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a  = av;
      b  = bv;
      @(posedge clk);
      exp_cur   = model(o, av, bv);
      exp_valid = 1'b1;
      #1;
      in_valid = 1'b0;
      op = 3'bxxx;
      a  = 'x;
      b  = 'x;
      lat = 1;
      while (!out_valid && lat < 100) begin
         check("busy in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) check("out_valid timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a  = '0;
      b  = '0;
      op = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset result", {16'd0, result}, 32'd0);
      check("reset cb", {31'd0, cb}, 32'd0);
      check("reset zero", {31'd0, zero}, 32'd0);
`ifdef SEQ_ALU_OVF_EN
      check("reset ovf", {31'd0, ovf}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      foreach (VECS[i]) begin
         do_op(VECS[i].op, VECS[i].a, VECS[i].b, lat);
         check($sformatf("v%0d latency", i), lat, {24'd0, VECS[i].lat});
         check($sformatf("v%0d result", i), {16'd0, result}, {16'd0, VECS[i].res});
         check($sformatf("v%0d cb", i), {31'd0, cb}, {31'd0, VECS[i].cb});
         check($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, VECS[i].z});
`ifdef SEQ_ALU_OVF_EN
         check($sformatf("v%0d ovf", i), {31'd0, ovf}, {31'd0, VECS[i].ovf});
`endif
         @(posedge clk); #1;
         check($sformatf("v%0d post out_valid", i), {31'd0, out_valid}, 32'd0);
         check($sformatf("v%0d post in_ready", i), {31'd0, in_ready}, 32'd1);
      end

      // Backpressure: result must hold while the consumer stalls, and new requests are ignored.
      out_ready = 1'b0;
      do_op(3'd7, 8'hF0, 8'h3C, lat);
      check("bp latency", lat, 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op = 3'd0;
         a  = 8'd1;
         b  = 8'd1;
         @(posedge clk); #1;
         check("bp out_valid", {31'd0, out_valid}, 32'd1);
         check("bp in_ready", {31'd0, in_ready}, 32'd0);
         check("bp result", {16'd0, result}, 32'h0000_00CC);
         check("bp cb", {31'd0, cb}, 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release out_valid", {31'd0, out_valid}, 32'd0);
      check("bp release in_ready", {31'd0, in_ready}, 32'd1);

      // Reset during a multiply: leave a nonzero result first so the clear is observable.
      do_op(3'd0, 8'd1, 8'd2, lat);
      check("pre-abort result", {16'd0, result}, 32'd3);
      @(posedge clk); #1;
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'd2;
      a  = 8'd255;
      b  = 8'd255;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("abort mul in_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n     = 1'b0;
      exp_valid = 1'b0;
      @(posedge clk); #1;
      check("abort out_valid", {31'd0, out_valid}, 32'd0);
      check("abort result", {16'd0, result}, 32'd0);
      check("abort in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check("abort no late output", {31'd0, out_valid}, 32'd0);
      end
      do_op(3'd0, 8'd1, 8'd1, lat);
      check("after abort latency", lat, 32'd1);
      check("after abort result", {16'd0, result}, 32'd2);
      check("after abort cb", {31'd0, cb}, 32'd0);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
